// File: rtl/write_ptr_full_pkg.sv
// -----------------------------------------------------------------------------
// write_ptr_full_pkg
// Shared FIFO helpers for the write-side pointer logic.
//   ptr_width()   : pointer width for a given memory address width. The extra
//                   MSB tells a full FIFO apart from an empty one.
//   gray_encode() : binary -> reflected Gray code. Callers cast the result down
//                   to their own pointer width.
// -----------------------------------------------------------------------------
package write_ptr_full_pkg;

  localparam int GRAY_MAX_W = 32;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray_encode(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/write_ptr_full_if.sv
// -----------------------------------------------------------------------------
// write_ptr_full_if
// Bundle of signals between a FIFO write-pointer block and its neighbours
// (producer, memory, and the read-domain synchronizer).
//   winc           producer write request
//   rptr_gray_sync read pointer (Gray), already synchronized into the write clock
//   wen / waddr    memory write enable and address
//   wptr_gray      registered Gray write pointer, sent to the read domain
//   full, almost_full, wlevel, overflow  registered status
// Modports:
//   slave  - the write_ptr_full block
//   master - the environment that drives requests and observes status
// -----------------------------------------------------------------------------
interface write_ptr_full_if
  import write_ptr_full_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) ();

  localparam int PW = ptr_width(ADDR_WIDTH);

  logic                  winc;
  logic [PW-1:0]         rptr_gray_sync;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [PW-1:0]         wptr_gray;
  logic                  full;
  logic                  almost_full;
  logic [PW-1:0]         wlevel;
  logic                  overflow;

  modport slave (
    input  winc, rptr_gray_sync,
    output wen, waddr, wptr_gray, full, almost_full, wlevel, overflow
  );

  modport master (
    output winc, rptr_gray_sync,
    input  wen, waddr, wptr_gray, full, almost_full, wlevel, overflow
  );

endinterface

// File: rtl/gray_to_binary.sv
// -----------------------------------------------------------------------------
// gray_to_binary
// Combinational Gray -> binary decoder.
//   gray_i : Gray-coded input, BITSIZE bits
//   bin_o  : binary value; bit i is the XOR of gray_i bits i..MSB
// -----------------------------------------------------------------------------
module gray_to_binary #(
  parameter int BITSIZE = 5
) (
  input  logic [BITSIZE-1:0] gray_i,
  output logic [BITSIZE-1:0] bin_o
);

  generate
    for (genvar gi = 0; gi < BITSIZE; gi++) begin : g_bit
      assign bin_o[gi] = ^gray_i[BITSIZE-1:gi];
    end
  endgenerate

endmodule

// File: rtl/write_ptr_full.sv
// -----------------------------------------------------------------------------
// write_ptr_full
// Write-side pointer and status block of a FIFO whose read pointer arrives as
// a synchronized Gray code.
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   wif  : write_ptr_full_if.slave (request, read pointer in, memory write
//          port and registered status out)
// Parameters:
//   ADDR_WIDTH : memory address width (>= 2), DEPTH = 2**ADDR_WIDTH
//   AF_THRESH  : almost-full level threshold (1..DEPTH)
// -----------------------------------------------------------------------------
module write_ptr_full
  import write_ptr_full_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 12
) (
  input  logic             clk,
  input  logic             rst,
  write_ptr_full_if.slave  wif
);

  localparam int            PW     = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

  logic [PW-1:0] wbin_q,   wbin_d;
  logic [PW-1:0] wgray_q,  wgray_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          full_q,   full_d;
  logic          af_q,     af_d;
  logic          ovf_q,    ovf_d;
  logic          wen;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rgray_full_pat;

  gray_to_binary #(
    .BITSIZE (PW)
  ) u_rptr_dec (
    .gray_i (wif.rptr_gray_sync),
    .bin_o  (rbin)
  );

  always_comb begin
    // Reset blocks the memory write too, so nothing lands in RAM while the
    // pointer is being forced to zero.
    wen      = wif.winc & ~full_q & ~rst;
    wbin_d   = wbin_q + PW'(wen);
    wgray_d  = PW'(gray_encode(GRAY_MAX_W'(wbin_d)));
    // Full when the next write pointer is exactly one lap ahead of the read
    // pointer: in Gray code that is the read pointer with its top two bits
    // inverted. Using the stale synchronized read pointer can only make
    // full linger, never clear early.
    rgray_full_pat = {~wif.rptr_gray_sync[PW-1:PW-2], wif.rptr_gray_sync[PW-3:0]};
    full_d   = (wgray_d == rgray_full_pat);
    wlevel_d = wbin_d - rbin;
    af_d     = (wlevel_d >= AF_LVL);
    ovf_d    = wif.winc & full_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wlevel_q <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wlevel_q <= wlevel_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
    end
  end

  assign wif.wen         = wen;
  assign wif.waddr       = wbin_q[ADDR_WIDTH-1:0];
  assign wif.wptr_gray   = wgray_q;
  assign wif.full        = full_q;
  assign wif.almost_full = af_q;
  assign wif.wlevel      = wlevel_q;
  assign wif.overflow    = ovf_q;

endmodule
